// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   XLEN             - datapath width
//   NOP_INSTR        - instruction presented to decode when the queue is empty
//   DEFAULT_RESET_PC - default first fetch address after reset
//   fetch_entry_t    - one queued fetch: {pc, instr}
package fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and decode.
//   IMemReq/IMemAddr    - read strobe and word address to memory
//   IMemRdata           - memory data, one cycle after IMemReq
//   Redirect/RedirectPC - taken branch/jump and its target
//   DecodeReady         - decode consumes the head entry this cycle
//   InstrValid/Instr/InstrPC - head entry to decode
//   Count               - queue occupancy
// DEPTH must match the DEPTH of the fetch_queue attached to it.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                               IMemReq;
  logic [fetch_queue_pkg::XLEN-1:0]   IMemAddr;
  logic [fetch_queue_pkg::XLEN-1:0]   IMemRdata;
  logic                               Redirect;
  logic [fetch_queue_pkg::XLEN-1:0]   RedirectPC;
  logic                               DecodeReady;
  logic                               InstrValid;
  logic [fetch_queue_pkg::XLEN-1:0]   Instr;
  logic [fetch_queue_pkg::XLEN-1:0]   InstrPC;
  logic [CW-1:0]                      Count;

  // master: the fetch queue itself
  modport master (
    output IMemReq, IMemAddr, InstrValid, Instr, InstrPC, Count,
    input  IMemRdata, Redirect, RedirectPC, DecodeReady
  );

  // slave: memory + decode side
  modport slave (
    input  IMemReq, IMemAddr, InstrValid, Instr, InstrPC, Count,
    output IMemRdata, Redirect, RedirectPC, DecodeReady
  );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush.
//   clk/rst    - clock, synchronous active-high reset
//   flush      - empties the FIFO; wins over push and pop
//   push/wdata - write an entry at the write pointer
//   pop        - advance the read pointer (caller guarantees non-empty)
//   rdata      - head entry (raw storage, not masked when empty)
//   count      - occupancy, 0..DEPTH
//   empty      - count == 0
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic                        full;

  // Storage is not reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // push+pop together leaves occupancy unchanged, even when full
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && !pop && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(pop && empty));
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one word fetch per cycle while there is
// room, buffers {pc, instr} pairs and presents the head to decode.
//   CLK      - clock
//   Reset    - synchronous active-high reset
//   bus      - fetch_queue_if.master (memory request/response, redirect,
//              decode handshake, occupancy)
// Parameters: DEPTH (power of two >= 2), RESET_PC (first fetch address).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           CLK,
  input  logic           Reset,
  fetch_queue_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;   // PC of the request whose data returns next cycle
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count;
  logic            empty, push, pop, req;
  logic [CW:0]     credit;
  fetch_entry_t    head, wentry;

  // Redirect cancels a pop and the returning response in the same cycle.
  assign pop  = !empty && bus.DecodeReady && !bus.Redirect;
  assign push = inflight_q && !bus.Redirect;

  // Slots already committed after this cycle's pop; an in-flight response
  // holds a slot so the FIFO can never be overrun.
  assign credit = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign req    = !Reset && !bus.Redirect && (credit < (CW+1)'(DEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    if (bus.Redirect) begin
      fetch_pc_d = bus.RedirectPC & 32'hFFFF_FFFC;
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;   // wraps to 0 past 32'hFFFF_FFFC
      req_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign wentry = '{pc: req_pc_q, instr: bus.IMemRdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .flush (bus.Redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  assign bus.IMemReq    = req;
  assign bus.IMemAddr   = fetch_pc_q;
  assign bus.InstrValid = !empty;
  assign bus.Instr      = empty ? NOP_INSTR : head.instr;
  assign bus.InstrPC    = empty ? '0 : head.pc;
  assign bus.Count      = count;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;

  fetch_queue_if #(.DEPTH(DEPTH)) bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: one entry per issued fetch, including the one still in flight
  // (at the back). Memory model returns addr + 0x100.
  fetch_entry_t sb[$];
  logic         mdl_inflight = 1'b0;
  logic [31:0]  mdl_pc       = RESET_PC;
  logic [31:0]  mem_pend     = 32'h0;
  logic [31:0]  stall_pc;

  always @(negedge CLK) begin : monitor
    int   mcount;
    logic mpop, exp_req;
    if (Reset) begin
      n_cmp++;
      if (bus.IMemReq !== 1'b0) begin
        n_err++; $display("FAIL sb_reset_req: IMemReq=%b want 0", bus.IMemReq);
      end
      sb.delete(); mdl_inflight = 1'b0; mdl_pc = RESET_PC;
    end else begin
      mcount = sb.size() - int'(mdl_inflight);
      n_cmp++;
      if (bus.Count !== CW'(mcount)) begin
        n_err++; $display("FAIL sb_count: Count=%0d want %0d", bus.Count, mcount);
      end
      n_cmp++;
      if (mcount == 0) begin
        if ({bus.InstrValid, bus.Instr, bus.InstrPC} !== {1'b0, NOP_INSTR, 32'h0}) begin
          n_err++; $display("FAIL sb_empty: vld=%b instr=%h pc=%h want 0/%h/0",
                            bus.InstrValid, bus.Instr, bus.InstrPC, NOP_INSTR);
        end
      end else begin
        if ({bus.InstrValid, bus.InstrPC, bus.Instr} !== {1'b1, sb[0].pc, sb[0].instr}) begin
          n_err++; $display("FAIL sb_head: vld=%b pc=%h instr=%h want 1/%h/%h",
                            bus.InstrValid, bus.InstrPC, bus.Instr, sb[0].pc, sb[0].instr);
        end
      end
      mpop = (mcount != 0) && bus.DecodeReady && !bus.Redirect;
      if (mpop) void'(sb.pop_front());
      exp_req = !bus.Redirect && (sb.size() < DEPTH);
      n_cmp++;
      if (bus.IMemReq !== exp_req) begin
        n_err++; $display("FAIL sb_req: IMemReq=%b want %b", bus.IMemReq, exp_req);
      end
      if (bus.Redirect) begin
        sb.delete(); mdl_inflight = 1'b0; mdl_pc = bus.RedirectPC & 32'hFFFF_FFFC;
      end else if (exp_req) begin
        n_cmp++;
        if (bus.IMemAddr !== mdl_pc) begin
          n_err++; $display("FAIL sb_addr: IMemAddr=%h want %h", bus.IMemAddr, mdl_pc);
        end
        sb.push_back('{pc: mdl_pc, instr: mdl_pc + 32'h100});
        mdl_pc = mdl_pc + 32'd4; mdl_inflight = 1'b1;
      end else begin
        mdl_inflight = 1'b0;
      end
    end
    // Non-requested cycles return junk so a stray write is visible.
    mem_pend = (!Reset && bus.IMemReq) ? bus.IMemAddr + 32'h100
                                       : (32'hBAD0_0000 | $urandom_range(0, 16'hFFFF));
  end

  always @(posedge CLK) begin
    #1 bus.IMemRdata = mem_pend;
  end

  task automatic test_reset();
    Reset = 1'b1; bus.DecodeReady = 1'b0; bus.Redirect = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({bus.IMemReq, bus.InstrValid, bus.Count} !== {1'b0, 1'b0, CW'(0)}) begin
      n_err++; $display("FAIL reset_ctl: req=%b vld=%b cnt=%0d want 0/0/0",
                        bus.IMemReq, bus.InstrValid, bus.Count);
    end
    n_cmp++;
    if ({bus.Instr, bus.InstrPC} !== {NOP_INSTR, 32'h0}) begin
      n_err++; $display("FAIL reset_out: instr=%h pc=%h want %h/0", bus.Instr, bus.InstrPC, NOP_INSTR);
    end
  endtask

  task automatic test_stream();
    @(posedge CLK); #1; Reset = 1'b0; bus.DecodeReady = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({bus.IMemReq, bus.IMemAddr, bus.InstrValid} !== {1'b1, RESET_PC, 1'b0}) begin
      n_err++; $display("FAIL stream_c0: req=%b addr=%h vld=%b want 1/%h/0",
                        bus.IMemReq, bus.IMemAddr, bus.InstrValid, RESET_PC);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.IMemReq, bus.IMemAddr, bus.InstrValid} !== {1'b1, RESET_PC + 32'd4, 1'b0}) begin
      n_err++; $display("FAIL stream_c1: req=%b addr=%h vld=%b want 1/%h/0",
                        bus.IMemReq, bus.IMemAddr, bus.InstrValid, RESET_PC + 32'd4);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr, bus.IMemAddr}
        !== {1'b1, RESET_PC, RESET_PC + 32'h100, RESET_PC + 32'd8}) begin
      n_err++; $display("FAIL stream_c2: vld=%b pc=%h instr=%h addr=%h want 1/%h/%h/%h",
                        bus.InstrValid, bus.InstrPC, bus.Instr, bus.IMemAddr,
                        RESET_PC, RESET_PC + 32'h100, RESET_PC + 32'd8);
    end
  endtask

  task automatic test_stall();
    @(posedge CLK); #1; bus.DecodeReady = 1'b0;
    @(negedge CLK); #1;
    stall_pc = sb[0].pc;
    for (int i = 1; i < 10; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({bus.InstrValid, bus.InstrPC, bus.Instr} !== {1'b1, stall_pc, stall_pc + 32'h100}) begin
        n_err++; $display("FAIL stall_hold[%0d]: vld=%b pc=%h instr=%h want 1/%h/%h", i,
                          bus.InstrValid, bus.InstrPC, bus.Instr, stall_pc, stall_pc + 32'h100);
      end
    end
    n_cmp++;
    if ({bus.Count, bus.IMemReq} !== {CW'(DEPTH), 1'b0}) begin
      n_err++; $display("FAIL stall_full: cnt=%0d req=%b want %0d/0", bus.Count, bus.IMemReq, DEPTH);
    end
  endtask

  // Drain from full: no bubble, and Count holds at DEPTH-1 under push+pop.
  task automatic test_drain();
    @(posedge CLK); #1; bus.DecodeReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [CW-1:0] ecnt;
      ecnt = (i == 0) ? CW'(DEPTH) : CW'(DEPTH - 1);
      @(negedge CLK);
      n_cmp++;
      if ({bus.InstrValid, bus.InstrPC, bus.Count} !== {1'b1, stall_pc + 32'(4 * i), ecnt}) begin
        n_err++; $display("FAIL drain[%0d]: vld=%b pc=%h cnt=%0d want 1/%h/%0d", i,
                          bus.InstrValid, bus.InstrPC, bus.Count, stall_pc + 32'(4 * i), ecnt);
      end
    end
  endtask

  task automatic test_redirect();
    @(posedge CLK); #1; bus.Redirect = 1'b1; bus.RedirectPC = 32'h0000_2003;
    @(negedge CLK);
    n_cmp++;
    if (bus.IMemReq !== 1'b0) begin
      n_err++; $display("FAIL redir_req: IMemReq=%b want 0", bus.IMemReq);
    end
    @(posedge CLK); #1; bus.Redirect = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({bus.IMemReq, bus.IMemAddr, bus.InstrValid} !== {1'b1, 32'h2000, 1'b0}) begin
      n_err++; $display("FAIL redir_r1: req=%b addr=%h vld=%b want 1/2000/0",
                        bus.IMemReq, bus.IMemAddr, bus.InstrValid);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.InstrValid, bus.Count} !== {1'b0, CW'(0)}) begin
      n_err++; $display("FAIL redir_kill: vld=%b cnt=%0d want 0/0", bus.InstrValid, bus.Count);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr} !== {1'b1, 32'h2000, 32'h2100}) begin
      n_err++; $display("FAIL redir_r3: vld=%b pc=%h instr=%h want 1/2000/2100",
                        bus.InstrValid, bus.InstrPC, bus.Instr);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge CLK); #1; bus.Redirect = 1'b1; bus.RedirectPC = 32'h0000_3000;
    @(posedge CLK); #1; bus.RedirectPC = 32'h0000_4000;
    @(negedge CLK);
    n_cmp++;
    if ({bus.IMemReq, bus.InstrValid} !== 2'b00) begin
      n_err++; $display("FAIL b2b_r1: req=%b vld=%b want 0/0", bus.IMemReq, bus.InstrValid);
    end
    @(posedge CLK); #1; bus.Redirect = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({bus.IMemReq, bus.IMemAddr} !== {1'b1, 32'h4000}) begin
      n_err++; $display("FAIL b2b_addr: req=%b addr=%h want 1/4000", bus.IMemReq, bus.IMemAddr);
    end
    @(negedge CLK);
    n_cmp++;
    if (bus.InstrValid !== 1'b0) begin
      n_err++; $display("FAIL b2b_early: vld=%b want 0", bus.InstrValid);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr} !== {1'b1, 32'h4000, 32'h4100}) begin
      n_err++; $display("FAIL b2b_head: vld=%b pc=%h instr=%h want 1/4000/4100",
                        bus.InstrValid, bus.InstrPC, bus.Instr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] eaddr[3];
    eaddr[0] = 32'hFFFF_FFF8; eaddr[1] = 32'hFFFF_FFFC; eaddr[2] = 32'h0;
    @(posedge CLK); #1; bus.Redirect = 1'b1; bus.RedirectPC = 32'hFFFF_FFF9;
    @(posedge CLK); #1; bus.Redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({bus.IMemReq, bus.IMemAddr} !== {1'b1, eaddr[i]}) begin
        n_err++; $display("FAIL wrap_addr[%0d]: req=%b addr=%h want 1/%h", i,
                          bus.IMemReq, bus.IMemAddr, eaddr[i]);
      end
    end
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr} !== {1'b1, 32'h0, 32'h100}) begin
      n_err++; $display("FAIL wrap_head: vld=%b pc=%h instr=%h want 1/0/100",
                        bus.InstrValid, bus.InstrPC, bus.Instr);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1; bus.Redirect = 1'b1; bus.RedirectPC = 32'h0000_5000; bus.DecodeReady = 1'b0;
    @(posedge CLK); #1; bus.Redirect = 1'b0;
    repeat (4) @(posedge CLK);
    #1; Reset = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({bus.Count, bus.IMemReq} !== {CW'(3), 1'b0}) begin
      n_err++; $display("FAIL rstmid_pre: cnt=%0d req=%b want 3/0", bus.Count, bus.IMemReq);
    end
    @(posedge CLK); #1; Reset = 1'b0; bus.DecodeReady = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({bus.InstrValid, bus.Count, bus.Instr, bus.InstrPC} !== {1'b0, CW'(0), NOP_INSTR, 32'h0}) begin
      n_err++; $display("FAIL rstmid_clr: vld=%b cnt=%0d instr=%h pc=%h want 0/0/%h/0",
                        bus.InstrValid, bus.Count, bus.Instr, bus.InstrPC, NOP_INSTR);
    end
    n_cmp++;
    if ({bus.IMemReq, bus.IMemAddr} !== {1'b1, RESET_PC}) begin
      n_err++; $display("FAIL rstmid_req: req=%b addr=%h want 1/%h", bus.IMemReq, bus.IMemAddr, RESET_PC);
    end
    @(negedge CLK);
    n_cmp++;
    if (bus.InstrValid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_stale: vld=%b want 0", bus.InstrValid);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr} !== {1'b1, RESET_PC, RESET_PC + 32'h100}) begin
      n_err++; $display("FAIL rstmid_first: vld=%b pc=%h instr=%h want 1/%h/%h",
                        bus.InstrValid, bus.InstrPC, bus.Instr, RESET_PC, RESET_PC + 32'h100);
    end
  endtask

  initial begin
    bus.Redirect = 1'b0; bus.RedirectPC = '0; bus.DecodeReady = 1'b0; bus.IMemRdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_drain();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
